unidade_controle_rodadas: RTL
=============================

Name: unidade_controle_rodadas

Overview:
- Parametrised successor of the single-pass memory-game control unit.
- The game runs NUM_RODADAS rounds; round k requires k+1 correct plays, so the sequence grows each round.
- Adds an optional per-play timeout, an internal round counter and a third terminal condition (timeout).
- Moore FSM; drives the datapath address counter (E) and play register (R) of the game datapath.

Parameters:
- NUM_RODADAS, 16, number of rounds (1..2^W_RODADA).
- W_RODADA, 4, width of the internal round counter and db_rodada.
- TIMEOUT_CICLOS, 3000, clock cycles allowed per play while timeout mode is enabled (>=2).
- W_TIMEOUT, 12, width of the timeout counter; must satisfy 2^W_TIMEOUT >= TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- iniciar  in  1  start/restart request
- jogada  in  1  play-detected pulse from datapath edge detector
- igual  in  1  registered play equals memory content at current address
- fimE  in  1  datapath address equals current round index (last play of the round)
- modo_timeout  in  1  1 = timeout enabled; sampled every cycle
- zeraE  out  1  clear address counter
- contaE  out  1  increment address counter
- zeraR  out  1  clear play register
- registraR  out  1  load play register
- acertou  out  1  game won
- errou  out  1  wrong play
- timeout  out  1  play not made in time
- pronto  out  1  game finished (any terminal state)
- db_estado  out  4  current state code
- db_rodada  out  W_RODADA  current round index, 0-based

Behaviour:
- One clock; reset is synchronous and active-high. On a rising clock edge with reset=1: state=inicial, round counter=0, timeout counter=0. Reset overrides every other input, including mid-game.
- Reset-state outputs: zeraE=1, zeraR=1, all other outputs=0, db_estado=0, db_rodada=0.
- States and codes:
  - inicial 0
  - inicializa 1
  - espera_jogada 4
  - registra 5
  - compara 6
  - proxima_jogada 7
  - proxima_rodada 8
  - fim_acertos C
  - fim_timeout D
  - fim_erro E
- Unused codes go to inicial on the next edge.
- Transitions:
  - inicial: iniciar -> inicializa, else stay.
  - inicializa: -> espera_jogada.
  - espera_jogada: jogada -> registra; else timeout condition -> fim_timeout; else stay.
  - registra: -> compara.
  - compara:
    - !igual -> fim_erro.
    - igual & !fimE -> proxima_jogada.
    - igual & fimE & round==NUM_RODADAS-1 -> fim_acertos.
    - igual & fimE & round<NUM_RODADAS-1 -> proxima_rodada.
  - proxima_jogada, proxima_rodada: -> espera_jogada.
  - fim_acertos / fim_erro / fim_timeout: iniciar -> inicializa (direct restart), else stay.
- Moore outputs:
  - zeraE in inicial, inicializa, proxima_rodada.
  - zeraR in inicial, inicializa.
  - registraR in registra.
  - contaE in proxima_jogada.
  - acertou in fim_acertos; errou in fim_erro; timeout in fim_timeout.
  - pronto in all three terminal states.
- Round counter:
  - Cleared in inicializa; +1 on the edge leaving proxima_rodada.
  - Never exceeds NUM_RODADAS-1; held in terminal states.
  - db_rodada = counter.
- Timeout counter:
  - Held at 0 in every state other than espera_jogada.
  - In espera_jogada: +1 per cycle, saturating at TIMEOUT_CICLOS-1.
  - Timeout condition = modo_timeout & counter==TIMEOUT_CICLOS-1 & !jogada.
  - First play of each wait: with no jogada, the state is espera_jogada for exactly TIMEOUT_CICLOS cycles, then fim_timeout.
- Simultaneous events:
  - jogada wins over timeout in the same cycle.
  - modo_timeout deasserted while waiting: counter saturates, no timeout fires.
  - Re-asserting modo_timeout at saturation fires the timeout on the next edge.
- Latency:
  - iniciar to espera_jogada: 2 edges.
  - jogada to compara: 2 edges.
  - compara to terminal state: 1 edge.

Test Plan:
- NUM_RODADAS=4: reset, pulse iniciar, play a correct sequence of 1,2,3,4 plays (fimE on the last of each round) -> passes through proxima_rodada 3 times, db_rodada 0->3, ends in C with acertou=1 and pronto=1.
- Round 2, second play, igual=0 -> fim_erro E: errou=1, pronto=1, db_rodada=2 held; then iniciar -> inicializa, db_rodada=0.
- TIMEOUT_CICLOS=8, modo_timeout=1, no jogada -> exactly 8 cycles in state 4, then D with timeout=1; with modo_timeout=0 -> stays in 4 indefinitely.
- jogada asserted on the same cycle the counter reaches 7 (TIMEOUT_CICLOS=8) -> registra, no timeout; counter is 0 on the next entry to espera_jogada.
- reset=1 for one edge while in compara during round 3 -> inicial next cycle: zeraE=1, zeraR=1, db_rodada=0, all result flags 0. Also force an unused code (e.g. 3) -> inicial.

Source files
------------

// File: rtl/unidade_controle_rodadas.sv
// -----------------------------------------------------------------------------
// unidade_controle_rodadas
// Control unit for the multi-round memory game. Round k needs k+1 correct
// plays, so the sequence to reproduce grows by one play each round. An
// optional per-play timeout ends the game when no play arrives in time.
//
// Handshake: there is no valid/ready pair here. jogada is a one-cycle
// pulse from the datapath edge detector, sampled only in espera_jogada;
// igual and fimE are levels sampled only in compara.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous active-high reset, overrides everything
//   iniciar       start / restart request
//   jogada        play-detected pulse
//   igual         registered play equals memory at current address
//   fimE          current address equals current round index
//   modo_timeout  1 = per-play timeout enabled (sampled every cycle)
//   zeraE/contaE  clear / increment datapath address counter
//   zeraR/registraR clear / load datapath play register
//   acertou/errou/timeout  terminal result flags
//   pronto        any terminal state
//   db_estado     current state code
//   db_rodada     current round index, 0-based
//
// All outputs are registered: they are decoded from the next state and
// loaded on the same edge as the state register, so they always match
// db_estado.
// -----------------------------------------------------------------------------
module unidade_controle_rodadas #(
   parameter int NUM_RODADAS    = 16,
   parameter int W_RODADA       = 4,
   parameter int TIMEOUT_CICLOS = 3000,
   parameter int W_TIMEOUT      = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar,
   input  logic                jogada,
   input  logic                igual,
   input  logic                fimE,
   input  logic                modo_timeout,
   output logic                zeraE,
   output logic                contaE,
   output logic                zeraR,
   output logic                registraR,
   output logic                acertou,
   output logic                errou,
   output logic                timeout,
   output logic                pronto,
   output logic [3:0]          db_estado,
   output logic [W_RODADA-1:0] db_rodada
);

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      INICIALIZA     = 4'h1,
      ESPERA_JOGADA  = 4'h4,
      REGISTRA       = 4'h5,
      COMPARA        = 4'h6,
      PROXIMA_JOGADA = 4'h7,
      PROXIMA_RODADA = 4'h8,
      FIM_ACERTOS    = 4'hC,
      FIM_TIMEOUT    = 4'hD,
      FIM_ERRO       = 4'hE
   } estado_t;

   localparam logic [W_RODADA-1:0]  ULTIMA_RODADA = W_RODADA'(NUM_RODADAS - 1);
   localparam logic [W_RODADA-1:0]  UM_RODADA     = W_RODADA'(1);
   localparam logic [W_TIMEOUT-1:0] LIMITE_TEMPO  = W_TIMEOUT'(TIMEOUT_CICLOS - 1);
   localparam logic [W_TIMEOUT-1:0] UM_TEMPO      = W_TIMEOUT'(1);

   estado_t              r_estado;
   estado_t              w_prox;
   logic [W_RODADA-1:0]  r_rodada;
   logic [W_TIMEOUT-1:0] r_tempo;

   logic r_zeraE, r_contaE, r_zeraR, r_registraR;
   logic r_acertou, r_errou, r_timeout, r_pronto;

   logic w_estourou;
   logic w_ultima_rodada;

   // Timeout only counts while no play arrives this cycle: jogada wins.
   assign w_estourou      = modo_timeout & (r_tempo == LIMITE_TEMPO) & ~jogada;
   assign w_ultima_rodada = (r_rodada == ULTIMA_RODADA);

   // Next-state decode
   always_comb begin
      w_prox = INICIAL;
      case (r_estado)
         INICIAL:        w_prox = iniciar ? INICIALIZA : INICIAL;
         INICIALIZA:     w_prox = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            if (jogada)          w_prox = REGISTRA;
            else if (w_estourou) w_prox = FIM_TIMEOUT;
            else                 w_prox = ESPERA_JOGADA;
         end
         REGISTRA:       w_prox = COMPARA;
         COMPARA: begin
            if (!igual)               w_prox = FIM_ERRO;
            else if (!fimE)           w_prox = PROXIMA_JOGADA;
            else if (w_ultima_rodada) w_prox = FIM_ACERTOS;
            else                      w_prox = PROXIMA_RODADA;
         end
         PROXIMA_JOGADA: w_prox = ESPERA_JOGADA;
         PROXIMA_RODADA: w_prox = ESPERA_JOGADA;
         FIM_ACERTOS:    w_prox = iniciar ? INICIALIZA : FIM_ACERTOS;
         FIM_TIMEOUT:    w_prox = iniciar ? INICIALIZA : FIM_TIMEOUT;
         FIM_ERRO:       w_prox = iniciar ? INICIALIZA : FIM_ERRO;
         default:        w_prox = INICIAL;  // unused codes recover here
      endcase
   end

   // State, counters and registered Moore outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado    <= INICIAL;
         r_rodada    <= '0;
         r_tempo     <= '0;
         r_zeraE     <= 1'b1;
         r_contaE    <= 1'b0;
         r_zeraR     <= 1'b1;
         r_registraR <= 1'b0;
         r_acertou   <= 1'b0;
         r_errou     <= 1'b0;
         r_timeout   <= 1'b0;
         r_pronto    <= 1'b0;
      end else begin
         r_estado <= w_prox;

         // Cleared on entry to inicializa so a restart shows round 0
         // while still in inicializa; advances when leaving proxima_rodada.
         if (w_prox == INICIALIZA)
            r_rodada <= '0;
         else if (r_estado == PROXIMA_RODADA)
            r_rodada <= r_rodada + UM_RODADA;

         // Counts only while staying in espera_jogada, so every entry to
         // the wait starts from zero. Saturates at the limit so that
         // re-enabling modo_timeout later fires on the next edge.
         if (r_estado == ESPERA_JOGADA && w_prox == ESPERA_JOGADA) begin
            if (r_tempo != LIMITE_TEMPO)
               r_tempo <= r_tempo + UM_TEMPO;
         end else begin
            r_tempo <= '0;
         end

         r_zeraE     <= (w_prox == INICIAL) || (w_prox == INICIALIZA) ||
                        (w_prox == PROXIMA_RODADA);
         r_zeraR     <= (w_prox == INICIAL) || (w_prox == INICIALIZA);
         r_registraR <= (w_prox == REGISTRA);
         r_contaE    <= (w_prox == PROXIMA_JOGADA);
         r_acertou   <= (w_prox == FIM_ACERTOS);
         r_errou     <= (w_prox == FIM_ERRO);
         r_timeout   <= (w_prox == FIM_TIMEOUT);
         r_pronto    <= (w_prox == FIM_ACERTOS) || (w_prox == FIM_ERRO) ||
                        (w_prox == FIM_TIMEOUT);
      end
   end

   assign zeraE     = r_zeraE;
   assign contaE    = r_contaE;
   assign zeraR     = r_zeraR;
   assign registraR = r_registraR;
   assign acertou   = r_acertou;
   assign errou     = r_errou;
   assign timeout   = r_timeout;
   assign pronto    = r_pronto;
   assign db_estado = r_estado;
   assign db_rodada = r_rodada;

endmodule
